// File: rtl/vp_pkg.sv
// vp_pkg: shared filter mode constants and channel width helper
package vp_pkg;
  localparam logic [1:0] VP_MODE_BYPASS = 2'd0;
  localparam logic [1:0] VP_MODE_GAUSS  = 2'd1;
  localparam logic [1:0] VP_MODE_SOBEL  = 2'd2;
  localparam logic [1:0] VP_MODE_SHARP  = 2'd3;
  function automatic int vp_cw(input int dw);
    return dw / 3;
  endfunction
endpackage

// File: rtl/vp_conv_channel.sv
// vp_conv_channel: one colour channel's weighted sums (S2) and normalise/saturate/mode select (S3)
module vp_conv_channel import vp_pkg::*; #(
  parameter int CW = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [8:0][CW-1:0]  i_px,
  input  logic [1:0]          i_mode,
  input  logic                i_en2,
  input  logic                i_en3,
  output logic [CW-1:0]       o_px
);
  localparam int W  = CW + 4;
  localparam int GW = CW + 3;
  logic [8:0][W-1:0] e;
  logic [CW-1:0] cen2, blur_s, sob_s, sh_s, res;
  logic [W-1:0]  blur2, sh2, nb, sob;
  logic [GW-1:0] gx2, gy2, ax, ay;
  for (genvar k = 0; k < 9; k++) begin : g_ext
    assign e[k] = W'(i_px[k]);
  end
  // sample index is row*3+col, row0 on top, col0 on the left
  always_ff @(posedge i_clk)
    if (i_en2) begin
      cen2  <= i_px[4];
      blur2 <= e[0] + (e[1] << 1) + e[2] + (e[3] << 1) + (e[4] << 2) + (e[5] << 1) + e[6] + (e[7] << 1) + e[8];
      gx2   <= GW'(e[2] + (e[5] << 1) + e[8] - e[0] - (e[3] << 1) - e[6]);
      gy2   <= GW'(e[6] + (e[7] << 1) + e[8] - e[0] - (e[1] << 1) - e[2]);
      sh2   <= (e[4] << 2) + e[4] - e[1] - e[3] - e[5] - e[7];
    end
  always_comb begin
    nb     = (blur2 + W'(8)) >> 4;
    ax     = gx2[GW-1] ? -gx2 : gx2;
    ay     = gy2[GW-1] ? -gy2 : gy2;
    sob    = W'(ax) + W'(ay);
    blur_s = |nb[W-1:CW] ? '1 : nb[CW-1:0];
    sob_s  = |sob[W-1:CW] ? '1 : sob[CW-1:0];
    sh_s   = sh2[W-1] ? '0 : |sh2[W-2:CW] ? '1 : sh2[CW-1:0];
    res    = i_mode == VP_MODE_BYPASS ? cen2 :
             i_mode == VP_MODE_GAUSS  ? blur_s :
             i_mode == VP_MODE_SOBEL  ? sob_s : sh_s;
  end
  always_ff @(posedge i_clk)
    if (!i_rstn) o_px <= '0;
    else if (i_en3) o_px <= res;
endmodule

// File: rtl/vp_conv3x3.sv
// vp_conv3x3: three-stage 3x3 convolution (bypass/Gaussian/Sobel/sharpen) on each RGB channel
module vp_conv3x3 import vp_pkg::*; #(
  parameter int DW = 12
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [9*DW-1:0] i_pixel_data,
  input  logic            i_pixel_data_valid,
  input  logic [1:0]      i_mode,
  output logic [DW-1:0]   o_pixel_data,
  output logic            o_pixel_valid
);
  localparam int CW = vp_cw(DW);
  logic [9*DW-1:0] win1;
  logic [1:0]      mode1, mode2;
  logic            v1, v2;
  always_ff @(posedge i_clk) begin
    v1            <= i_rstn && i_pixel_data_valid;
    v2            <= i_rstn && v1;
    o_pixel_valid <= i_rstn && v2;
    if (i_pixel_data_valid) begin
      win1  <= i_pixel_data;
      mode1 <= i_mode;
    end
    if (v1) mode2 <= mode1;
  end
  for (genvar h = 0; h < 3; h++) begin : g_ch
    logic [8:0][CW-1:0] px;
    for (genvar k = 0; k < 9; k++) begin : g_px
      assign px[k] = win1[k*DW + h*CW +: CW];
    end
    vp_conv_channel #(.CW(CW)) u_ch (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_px   (px),
      .i_mode (mode2),
      .i_en2  (v1),
      .i_en3  (v2),
      .o_px   (o_pixel_data[h*CW +: CW])
    );
  end
endmodule
